// File: rtl/sram_mem_tester.sv
// SRAM self-test master: writes seed^addr over a range, reads it back, counts mismatches.
// Optional SRAM_TESTER_INVERT_PASS_EN adds a second write/read pass with the inverted pattern.
module sram_mem_tester #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic [1:0]        m_byte_enable,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_write_data,
  input  logic [DATA_W-1:0] m_read_data
);

  localparam int unsigned WAIT_W = 3;
  localparam int unsigned LAST   = READ_LATENCY - 1;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   start_q;
  logic [ADDR_W-1:0]   end_q;
  logic [DATA_W-1:0]   seed_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [DATA_W-1:0]   err_cnt_q;
  logic [ADDR_W-1:0]   first_err_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic                m_cs_q;
  logic [1:0]          m_be_q;
  logic                m_read_q;
  logic                m_write_q;
  logic [DATA_W-1:0]   m_wdata_q;

  // Read-return tracker: {valid, addr, expected} aligned with m_read_data
  logic                pipe_vld_q  [READ_LATENCY];
  logic [ADDR_W-1:0]   pipe_addr_q [READ_LATENCY];
  logic [DATA_W-1:0]   pipe_data_q [READ_LATENCY];

  logic                phase_c;
  logic                mismatch_c;

`ifdef SRAM_TESTER_INVERT_PASS_EN
  logic                phase_q;
  assign phase_c = phase_q;
`else
  assign phase_c = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a,
                                                input logic              inv);
    logic [DATA_W-1:0] p;
    p = s ^ DATA_W'(a);
    return inv ? ~p : p;
  endfunction

  assign mismatch_c = pipe_vld_q[LAST] && (m_read_data != pipe_data_q[LAST]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      start_q     <= '0;
      end_q       <= '0;
      seed_q      <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      m_addr_q    <= '0;
      m_cs_q      <= 1'b0;
      m_be_q      <= 2'b00;
      m_read_q    <= 1'b0;
      m_write_q   <= 1'b0;
      m_wdata_q   <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_addr_q[i] <= '0;
        pipe_data_q[i] <= '0;
      end
`ifdef SRAM_TESTER_INVERT_PASS_EN
      phase_q     <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      m_cs_q    <= 1'b0;
      m_be_q    <= 2'b00;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;

      pipe_vld_q[0]  <= m_read_q;
      pipe_addr_q[0] <= m_addr_q;
      pipe_data_q[0] <= pattern(seed_q, m_addr_q, phase_c);
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end

      // Zero count means this is the first mismatch of the test
      if (mismatch_c) begin
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + DATA_W'(1);
        end
        if (err_cnt_q == '0) begin
          first_err_q <= pipe_addr_q[LAST];
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            start_q     <= start_addr;
            end_q       <= end_addr;
            seed_q      <= seed;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
`ifdef SRAM_TESTER_INVERT_PASS_EN
            phase_q     <= 1'b0;
`endif
            if (start_addr > end_addr) begin
              state_q <= S_DONE;
            end else begin
              state_q   <= S_WRITE;
              busy_q    <= 1'b1;
              addr_q    <= start_addr;
              m_addr_q  <= start_addr;
              m_wdata_q <= pattern(seed, start_addr, 1'b0);
              m_write_q <= 1'b1;
              m_cs_q    <= 1'b1;
              m_be_q    <= 2'b11;
            end
          end
        end

        S_WRITE: begin
          if (addr_q == end_q) begin
            state_q  <= S_READ;
            addr_q   <= start_q;
            m_addr_q <= start_q;
            m_read_q <= 1'b1;
            m_cs_q   <= 1'b1;
            m_be_q   <= 2'b11;
          end else begin
            addr_q    <= addr_q + ADDR_W'(1);
            m_addr_q  <= addr_q + ADDR_W'(1);
            m_wdata_q <= pattern(seed_q, addr_q + ADDR_W'(1), phase_c);
            m_write_q <= 1'b1;
            m_cs_q    <= 1'b1;
            m_be_q    <= 2'b11;
          end
        end

        S_READ: begin
          if (addr_q == end_q) begin
            state_q <= S_WAIT;
            wait_q  <= '0;
          end else begin
            addr_q   <= addr_q + ADDR_W'(1);
            m_addr_q <= addr_q + ADDR_W'(1);
            m_read_q <= 1'b1;
            m_cs_q   <= 1'b1;
            m_be_q   <= 2'b11;
          end
        end

        S_WAIT: begin
          if (wait_q == WAIT_W'(LAST)) begin
`ifdef SRAM_TESTER_INVERT_PASS_EN
            if (!phase_q) begin
              phase_q   <= 1'b1;
              state_q   <= S_WRITE;
              addr_q    <= start_q;
              m_addr_q  <= start_q;
              m_wdata_q <= pattern(seed_q, start_q, 1'b1);
              m_write_q <= 1'b1;
              m_cs_q    <= 1'b1;
              m_be_q    <= 2'b11;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end
`else
            state_q <= S_DONE;
            busy_q  <= 1'b0;
`endif
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end

        // Last compare has landed in err_cnt_q by the time DONE is evaluated
        S_DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (err_cnt_q == '0) && (start_q <= end_q);
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign error_count    = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign m_address      = m_addr_q;
  assign m_chipselect   = m_cs_q;
  assign m_byte_enable  = m_be_q;
  assign m_read         = m_read_q;
  assign m_write        = m_write_q;
  assign m_write_data   = m_wdata_q;

endmodule

// File: tb/tb_sram_mem_tester.sv
// Scoreboard bench for sram_mem_tester: reference model queues expected bus accesses and results.
module tb_sram_mem_tester;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic [DW-1:0] seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic [DW-1:0] error_count;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] m_address;
  logic          m_chipselect;
  logic [1:0]    m_byte_enable;
  logic          m_read;
  logic          m_write;
  logic [DW-1:0] m_write_data;
  logic [DW-1:0] m_read_data;

  sram_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_err_addr(first_err_addr),
    .m_address(m_address), .m_chipselect(m_chipselect),
    .m_byte_enable(m_byte_enable), .m_read(m_read), .m_write(m_write),
    .m_write_data(m_write_data), .m_read_data(m_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            off;
  } acc_t;

  typedef struct {
    bit            pass;
    logic [DW-1:0] err;
    logic [AW-1:0] first;
    int            lat;
  } res_t;

  acc_t acc_q[$];
  res_t res_q[$];
  acc_t mon_e;
  res_t mon_r;
  res_t last_res;
  int   cyc = 0;
  int   start_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Memory model with optional read-side fault at one address
  logic [DW-1:0] mem [logic [AW-1:0]];
  bit            fault_en = 1'b0;
  logic [AW-1:0] fault_addr = '0;
  logic [DW-1:0] fault_val = '0;
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_chipselect && m_write) mem[m_address] = m_write_data;
    if (m_chipselect && m_read)
      rd_pipe[0] <= (fault_en && m_address == fault_addr) ? fault_val :
                    (mem.exists(m_address) ? mem[m_address] : '0);
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m_read_data = rd_pipe[RL-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every bus access and done pulse is matched against the queues
  always @(negedge clk) begin
    if (!reset) begin
      if (m_chipselect) begin
        chk("rd_wr_exclusive", 64'(m_read & m_write), 64'(0));
        chk("byte_enable", 64'(m_byte_enable), 64'(3));
        if (acc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_access: got addr %0h wr %0b, expected no access", m_address, m_write);
        end else begin
          mon_e = acc_q.pop_front();
          chk("acc_write", 64'(m_write), 64'(mon_e.wr));
          chk("acc_read", 64'(m_read), 64'(!mon_e.wr));
          chk("acc_addr", 64'(m_address), 64'(mon_e.addr));
          if (mon_e.wr) chk("wr_data", 64'(m_write_data), 64'(mon_e.data));
          chk("acc_cycle", 64'(cyc - start_cyc), 64'(mon_e.off));
        end
      end else begin
        chk("idle_strobes", 64'({m_read, m_write, m_byte_enable}), 64'(0));
      end
      if (done) begin
        if (res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          mon_r = res_q.pop_front();
          chk("res_pass", 64'(pass), 64'(mon_r.pass));
          chk("res_err", 64'(error_count), 64'(mon_r.err));
          chk("res_first", 64'(first_err_addr), 64'(mon_r.first));
          chk("done_latency", 64'(cyc - start_cyc), 64'(mon_r.lat));
          chk("busy_at_done", 64'(busy), 64'(0));
        end
      end
    end
  end

  // Reference model: expected accesses, timing offsets and results from the rules
  task automatic model_push(input logic [AW-1:0] s, input logic [AW-1:0] e,
                            input logic [DW-1:0] sd, input bit fen,
                            input logic [AW-1:0] fa, input logic [DW-1:0] fv);
    res_t          r;
    int            n;
    int            phases;
    int            base;
    logic [AW-1:0] a;
    logic [DW-1:0] p;
    logic [DW-1:0] rv;
`ifdef SRAM_TESTER_INVERT_PASS_EN
    phases = 2;
`else
    phases = 1;
`endif
    r.pass  = 1'b0;
    r.err   = '0;
    r.first = '0;
    r.lat   = 1;
    if (s <= e) begin
      n = int'(e - s) + 1;
      for (int ph = 0; ph < phases; ph++) begin
        base = ph * (2 * n + RL);
        for (int k = 0; k < n; k++) begin
          a = s + AW'(k);
          p = sd ^ a[DW-1:0];
          if (ph == 1) p = ~p;
          acc_q.push_back('{1'b1, a, p, base + k});
        end
        for (int k = 0; k < n; k++) begin
          a = s + AW'(k);
          p = sd ^ a[DW-1:0];
          if (ph == 1) p = ~p;
          rv = (fen && a == fa) ? fv : p;
          acc_q.push_back('{1'b0, a, '0, base + n + k});
          if (rv !== p) begin
            if (r.err == '0) r.first = a;
            if (r.err != '1) r.err = r.err + 1'b1;
          end
        end
      end
      r.pass = (r.err == '0);
      r.lat  = phases * (2 * n + RL) + 1;
    end
    res_q.push_back(r);
    last_res   = r;
    fault_en   = fen;
    fault_addr = fa;
    fault_val  = fv;
  endtask

  task automatic drive_start(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [DW-1:0] sd);
    @(negedge clk);
    start      = 1'b1;
    start_addr = s;
    end_addr   = e;
    seed       = sd;
    start_cyc  = cyc + 1;
    @(negedge clk);
    start      = 1'b0;
    start_addr = AW'($urandom);
    end_addr   = AW'($urandom);
    seed       = DW'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (res_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (res_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no done within 400 cycles, expected done");
      acc_q.delete();
      res_q.delete();
    end
    repeat (3) @(negedge clk);
    chk("hold_pass", 64'(pass), 64'(last_res.pass));
    chk("hold_err", 64'(error_count), 64'(last_res.err));
    chk("hold_first", 64'(first_err_addr), 64'(last_res.first));
    chk("hold_busy", 64'(busy), 64'(0));
  endtask

  task automatic run_test(input logic [AW-1:0] s, input logic [AW-1:0] e,
                          input logic [DW-1:0] sd, input bit fen,
                          input logic [AW-1:0] fa, input logic [DW-1:0] fv, input bit poke);
    model_push(s, e, sd, fen, fa, fv);
    drive_start(s, e, sd);
    chk("busy_after_start", 64'(busy), 64'(s <= e));
    if (poke && s <= e) begin
      start      = 1'b1;
      start_addr = AW'($urandom);
      end_addr   = start_addr;
      seed       = DW'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    logic [AW-1:0] s;
    logic [AW-1:0] e;
    int            n;

    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    seed       = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_err", 64'(error_count), 64'(0));
    chk("rst_first", 64'(first_err_addr), 64'(0));
    chk("rst_addr", 64'(m_address), 64'(0));
    chk("rst_cs", 64'(m_chipselect), 64'(0));
    chk("rst_be", 64'(m_byte_enable), 64'(0));
    chk("rst_read", 64'(m_read), 64'(0));
    chk("rst_write", 64'(m_write), 64'(0));
    chk("rst_wdata", 64'(m_write_data), 64'(0));
    reset = 1'b0;

    run_test(18'd0, 18'd3, 16'hA5A5, 1'b0, 18'd0, 16'h0, 1'b0);
    run_test(18'd0, 18'd3, 16'hA5A5, 1'b1, 18'd2, 16'hA5A6, 1'b0);
    run_test(18'd5, 18'd5, 16'h0000, 1'b0, 18'd0, 16'h0, 1'b0);
    run_test(18'd10, 18'd4, 16'h1234, 1'b0, 18'd0, 16'h0, 1'b0);

    // Reset on the second write cycle abandons the run without a done pulse
    model_push(18'd0, 18'd3, 16'hA5A5, 1'b0, 18'd0, 16'h0);
    drive_start(18'd0, 18'd3, 16'hA5A5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    acc_q.delete();
    res_q.delete();
    chk("midrst_write", 64'(m_write), 64'(0));
    chk("midrst_cs", 64'(m_chipselect), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    run_test(18'd0, 18'd3, 16'hA5A5, 1'b0, 18'd0, 16'h0, 1'b0);

    run_test(18'h3FFFD, 18'h3FFFF, 16'h5A5A, 1'b0, 18'd0, 16'h0, 1'b0);
    run_test(18'h3FFFD, 18'h3FFFF, 16'h5A5A, 1'b1, 18'h3FFFF, 16'h0000, 1'b1);
    run_test(18'd0, 18'd1, 16'h0000, 1'b0, 18'd0, 16'h0, 1'b1);

    for (int it = 0; it < 24; it++) begin
      n = int'($urandom_range(8, 1));
      if ($urandom_range(5) == 0) begin
        e = AW'($urandom_range(1000));
        s = e + AW'($urandom_range(50, 1));
      end else begin
        s = AW'($urandom_range((1 << AW) - 10));
        e = s + AW'(n - 1);
      end
      run_test(s, e, DW'($urandom), 1'($urandom), s + AW'($urandom_range(n - 1)),
               DW'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
